// File: rtl/rom_stats_pkg.sv
// Shared definitions for the grade-ROM statistics sequencer:
// controller state encoding, default widths and a ceil(log2) helper.
package rom_stats_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int ADDR_W_DEF    = 8;
  localparam int DEPTH_DEF     = 11;
  localparam int ACC_W_DEF     = 12;
  localparam int PASS_MARK_DEF = 90;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Number of bits needed to hold values 0..v-1 (at least 1).
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rom_stats_seq_divider.sv
// seq_divider: restoring divider, ACC_W-bit dividend by a constant divisor.
// The first quotient bit is produced on the load edge itself, so the whole
// quotient is ready ACC_W edges after load begins; done pulses for one
// cycle while quotient/remainder hold the final result.
module seq_divider
  import rom_stats_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int DIVISOR = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [ACC_W-1:0] dividend,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] quotient,
  output logic [ACC_W-1:0] remainder
);

  localparam int CNT_W = clog2(ACC_W + 1);

  logic [ACC_W-1:0] dvd_q, dvd_d;
  logic [ACC_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [ACC_W-1:0] src_dvd;
  logic [ACC_W-1:0] src_rem;
  logic [ACC_W:0]   trial;
  logic             fits;
  logic             last;

  // One restoring step per cycle: shift in the next dividend bit, subtract
  // the divisor when it fits, and shift the quotient bit into the dividend
  // register's vacated LSB.
  always_comb begin
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    src_dvd = load ? dividend : dvd_q;
    src_rem = load ? '0 : rem_q;
    trial   = {src_rem, src_dvd[ACC_W-1]};
    fits    = (trial >= (ACC_W + 1)'(DIVISOR));
    last    = load ? (ACC_W == 1) : (cnt_q == CNT_W'(1));
    if (load || busy_q) begin
      dvd_d  = {src_dvd[ACC_W-2:0], fits};
      rem_d  = fits ? ACC_W'(trial - (ACC_W + 1)'(DIVISOR)) : ACC_W'(trial);
      cnt_d  = load ? CNT_W'(ACC_W - 1) : (cnt_q - CNT_W'(1));
      busy_d = !last;
      done_d = last;
    end
  end

  // Divider state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      dvd_q  <= dvd_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = dvd_q;
  assign remainder = rem_q;

endmodule

// File: rtl/rom_stats_sequencer.sv
// rom_stats_sequencer: walks a synchronous-read grade ROM, accumulating
// sum/max/min, divides the sum by DEPTH for the average and publishes all
// results together with a one-cycle done pulse.
// Optional feature macro: STATS_PASS_COUNT_EN (count of entries >= PASS_MARK).
module rom_stats_sequencer
  import rom_stats_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int PASS_MARK = PASS_MARK_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  sum,
  output logic [DATA_W-1:0] max_val,
  output logic [DATA_W-1:0] min_val,
  output logic [DATA_W-1:0] avg,
  output logic [ADDR_W-1:0] pass_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t state_q, state_d;

  // Scan bookkeeping: iss marks a cycle that presents a new address, vld is
  // iss delayed by the ROM's one-cycle read latency.
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              iss_q, iss_d;
  logic              vld_q, vld_d;

  // Working statistics for the scan in progress.
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [DATA_W-1:0] min_q, min_d;

  // Published results, only rewritten on entry to DONE.
  logic [ACC_W-1:0]  sum_q, sum_d;
  logic [DATA_W-1:0] max_val_q, max_val_d;
  logic [DATA_W-1:0] min_val_q, min_val_d;
  logic [DATA_W-1:0] avg_q, avg_d;

  logic              accept;
  logic              word_vld;
  logic              div_fin;
  logic              div_load;
  logic              div_busy;
  logic              div_done;
  logic [ACC_W-1:0]  div_quo;
  logic [ACC_W-1:0]  div_rem;

  // Quotient never exceeds the largest entry, but clamp rather than wrap.
  function automatic logic [DATA_W-1:0] sat_avg(input logic [ACC_W-1:0] q);
    if (q > ACC_W'((2 ** DATA_W) - 1)) return '1;
    return q[DATA_W-1:0];
  endfunction

  assign accept   = (state_q == IDLE) && start;
  assign word_vld = (state_q == SCAN) && vld_q;
  assign div_load = word_vld && !iss_q;
  // A finished restoring divide always leaves remainder below the divisor.
  assign div_fin  = (state_q == DIV) && div_done && !div_busy &&
                    (div_rem < ACC_W'(DEPTH));

  seq_divider #(
    .ACC_W   (ACC_W),
    .DIVISOR (DEPTH)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (div_load),
    .dividend  (acc_d),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Next-state, address sequencing, accumulation and result publication.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    iss_d     = iss_q;
    vld_d     = 1'b0;
    acc_d     = acc_q;
    max_d     = max_q;
    min_d     = min_q;
    sum_d     = sum_q;
    max_val_d = max_val_q;
    min_val_d = min_val_q;
    avg_d     = avg_q;
    case (state_q)
      IDLE: begin
        addr_d = '0;
        if (accept) begin
          state_d = SCAN;
          acc_d   = '0;
          max_d   = '0;
          min_d   = '1;
          iss_d   = 1'b1;
        end
      end
      SCAN: begin
        vld_d = iss_q;
        if (iss_q) begin
          if (addr_q == LAST_ADDR) iss_d = 1'b0;
          else                     addr_d = addr_q + ADDR_W'(1);
        end
        if (word_vld) begin
          acc_d = acc_q + ACC_W'(rom_data);
          if (rom_data > max_q) max_d = rom_data;
          if (rom_data < min_q) min_d = rom_data;
        end
        if (div_load) state_d = DIV;
      end
      DIV: begin
        if (div_fin) begin
          state_d   = DONE;
          sum_d     = acc_q;
          max_val_d = max_q;
          min_val_d = min_q;
          avg_d     = sat_avg(div_quo);
        end
      end
      DONE: begin
        addr_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      iss_q     <= 1'b0;
      vld_q     <= 1'b0;
      acc_q     <= '0;
      max_q     <= '0;
      min_q     <= '1;
      sum_q     <= '0;
      max_val_q <= '0;
      min_val_q <= '1;
      avg_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      iss_q     <= iss_d;
      vld_q     <= vld_d;
      acc_q     <= acc_d;
      max_q     <= max_d;
      min_q     <= min_d;
      sum_q     <= sum_d;
      max_val_q <= max_val_d;
      min_val_q <= min_val_d;
      avg_q     <= avg_d;
    end
  end

`ifdef STATS_PASS_COUNT_EN
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pass_q, pass_d;

  // Count qualifying words during the scan; publish alongside the others.
  always_comb begin
    pc_d   = pc_q;
    pass_d = pass_q;
    if (accept) pc_d = '0;
    else if (word_vld && (rom_data >= DATA_W'(PASS_MARK))) pc_d = pc_q + ADDR_W'(1);
    if (div_fin) pass_d = pc_q;
  end

  // Pass counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      pass_q <= '0;
    end else begin
      pc_q   <= pc_d;
      pass_q <= pass_d;
    end
  end

  assign pass_cnt = pass_q;
`else
  assign pass_cnt = '0;
`endif

  assign rom_addr = addr_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign max_val  = max_val_q;
  assign min_val  = min_val_q;
  assign avg      = avg_q;

endmodule

// File: tb/tb_rom_stats_sequencer.sv
// Directed bench for rom_stats_sequencer with the production grade table.
// Cycle c = the c-th falling edge after the rising edge that accepts start.
module tb_rom_stats_sequencer;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 11;
  localparam int ACC_W  = 12;
`ifdef STATS_PASS_COUNT_EN
  localparam int EXP_PASS = 9;
`else
  localparam int EXP_PASS = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              busy;
  logic              done;
  logic [ACC_W-1:0]  sum;
  logic [DATA_W-1:0] max_val;
  logic [DATA_W-1:0] min_val;
  logic [DATA_W-1:0] avg;
  logic [ADDR_W-1:0] pass_cnt;

  logic [DATA_W-1:0] tbl [0:DEPTH-1];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Synchronous-read ROM with registered output.
  always @(posedge clk) begin
    if (int'(rom_addr) < DEPTH) rom_data <= tbl[rom_addr];
    else                        rom_data <= '0;
  end

  rom_stats_sequencer #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .ACC_W     (ACC_W),
    .PASS_MARK (90)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .max_val  (max_val),
    .min_val  (min_val),
    .avg      (avg),
    .pass_cnt (pass_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_results(input string tag);
    chk({tag, ".sum"}, 32'(sum), 996);
    chk({tag, ".max"}, 32'(max_val), 103);
    chk({tag, ".min"}, 32'(min_val), 56);
    chk({tag, ".avg"}, 32'(avg), 90);
    chk({tag, ".pass"}, 32'(pass_cnt), EXP_PASS);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".addr"}, 32'(rom_addr), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".sum"}, 32'(sum), 0);
    chk({tag, ".max"}, 32'(max_val), 0);
    chk({tag, ".min"}, 32'(min_val), 255);
    chk({tag, ".avg"}, 32'(avg), 0);
    chk({tag, ".pass"}, 32'(pass_cnt), 0);
  endtask

  // One start pulse; optional extra start pulses at cycles pa/pb while busy.
  task automatic run_scan(input string tag, input int pa, input int pb,
                          input logic [31:0] prev_sum);
    int ndone;
    int done_cyc;
    ndone    = 0;
    done_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c <= DEPTH) chk({tag, ".addr"}, 32'(rom_addr), 32'(c - 1));
      if (c == 1)  chk({tag, ".busy_first"}, 32'(busy), 1);
      if (c == 10) chk({tag, ".sum_hold"}, 32'(sum), prev_sum);
      if (c == 25) chk({tag, ".busy_at_done"}, 32'(busy), 1);
      if (c == 26) chk({tag, ".busy_after"}, 32'(busy), 0);
      if (done) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = c;
          check_results({tag, ".at_done"});
        end
      end
      start = (c == pa) || (c == pb);
    end
    start = 1'b0;
    chk({tag, ".done_cycle"}, 32'(done_cyc), 25);
    chk({tag, ".done_count"}, 32'(ndone), 1);
    check_results({tag, ".held"});
  endtask

  initial begin
    int ndone;
    int busy_seen;
    int dq[$];

    tbl[0] = 8'd95;  tbl[1] = 8'd90;  tbl[2]  = 8'd96; tbl[3] = 8'd98;
    tbl[4] = 8'd93;  tbl[5] = 8'd94;  tbl[6]  = 8'd97; tbl[7] = 8'd103;
    tbl[8] = 8'd56;  tbl[9] = 8'd97;  tbl[10] = 8'd77;

    // T1: reset values, then idle with no start
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("t1_reset");
    rst_n = 1'b1;
    ndone = 0;
    busy_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) busy_seen++;
    end
    chk("t1_idle_done", 32'(ndone), 0);
    chk("t1_idle_busy", 32'(busy_seen), 0);
    check_reset_state("t1_idle");

    // T2/T3: single scan with address trace
    run_scan("t2", -1, -1, 32'd0);

    // T4: start pulses while busy are ignored
    run_scan("t4", 5, 20, 32'd996);

    // T5: reset mid-scan, then a clean scan
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("t5_busy_before_rst", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_reset_state("t5_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run_scan("t5", -1, -1, 32'd0);

    // T6: start held high -> back-to-back scans
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 90; c++) begin
      @(negedge clk);
      if (done) begin
        dq.push_back(c);
        check_results("t6_done");
      end
      if (c == 60) start = 1'b0;
    end
    start = 1'b0;
    chk("t6_done_count", 32'(dq.size()), 3);
    if (dq.size() == 3) begin
      chk("t6_first", 32'(dq[0]), 25);
      chk("t6_gap1", 32'(dq[1] - dq[0]), 26);
      chk("t6_gap2", 32'(dq[2] - dq[1]), 26);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
